// File: rtl/decode_stage_pricol_pkg.sv
// decode_stage_pricol_pkg: opcodes, selector encodings, ALU ops and the decode control word.
package decode_stage_pricol_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSTR_MRET = 32'h30200073;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [2:0] {B_RS2, B_IMMI, B_IMMU, B_IMMS, B_CONST4} b_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_CSR} wb_sel_e;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;
  typedef struct packed {
    a_sel_e      a_sel;
    b_sel_e      b_sel;
    alu_op_e     alu_op;
    logic [2:0]  csr_op;
    logic        csr_we;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        gpr_we;
    wb_sel_e     wb_sel;
    logic        illegal_instr;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        mret;
  } decode_ctrl_t;
  localparam int CTRL_W = $bits(decode_ctrl_t);
  // alt selects SUB/SRA; callers only raise it where the encoding allows
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_pricol_if.sv
// decode_stage_pricol_if: fetch-side and execute-side handshakes of the decode stage.
interface decode_stage_pricol_if #(parameter int DEPTH = 4, parameter int XLEN = 32);
  import decode_stage_pricol_pkg::*;
  logic                         flush_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [31:0]                  instr_i;
  logic [XLEN-1:0]              pc_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [CTRL_W-1:0]            ctrl_o;
  logic [31:0]                  instr_o;
  logic [XLEN-1:0]              pc_o;
  logic [$clog2(DEPTH+1)-1:0]   fill_o;
  modport slave (
    input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, ctrl_o, instr_o, pc_o, fill_o
  );
  modport master (
    output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, ctrl_o, instr_o, pc_o, fill_o
  );
endinterface

// File: rtl/decode_stage_pricol_comb.sv
// decode_comb_pricol: combinational RV32I+Zicsr+MRET decoder; DECODE_STAGE_RV32M_EN adds RV32M.
module decode_comb_pricol
  import decode_stage_pricol_pkg::*;
(
  input  logic [31:0]  i_instr,
  output decode_ctrl_t o_ctrl
);
  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic       w_legal;
  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  always_comb begin
    o_ctrl  = '0;
    w_legal = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        o_ctrl.a_sel  = A_ZERO;
        o_ctrl.b_sel  = B_IMMU;
        o_ctrl.gpr_we = 1'b1;
        w_legal       = 1'b1;
      end
      OPC_AUIPC: begin
        o_ctrl.a_sel  = A_PC;
        o_ctrl.b_sel  = B_IMMU;
        o_ctrl.gpr_we = 1'b1;
        w_legal       = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        o_ctrl.a_sel  = A_PC;
        o_ctrl.b_sel  = B_CONST4;
        o_ctrl.gpr_we = 1'b1;
        o_ctrl.jal    = w_opc == OPC_JAL;
        o_ctrl.jalr   = w_opc == OPC_JALR;
        w_legal       = w_opc == OPC_JAL || w_f3 == 3'd0;
      end
      OPC_BRANCH: begin
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.branch = 1'b1;
        w_legal       = w_f3[2:1] != 2'b01;
      end
      OPC_LOAD: begin
        o_ctrl.b_sel    = B_IMMI;
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.mem_size = w_f3;
        o_ctrl.gpr_we   = 1'b1;
        o_ctrl.wb_sel   = WB_MEM;
        w_legal         = w_f3[1:0] != 2'b11 && w_f3 != 3'b110;
      end
      OPC_STORE: begin
        o_ctrl.b_sel    = B_IMMS;
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.mem_we   = 1'b1;
        o_ctrl.mem_size = w_f3;
        w_legal         = w_f3 < 3'd3;
      end
      OPC_OPIMM: begin
        o_ctrl.b_sel  = B_IMMI;
        o_ctrl.alu_op = alu_from_f3(w_f3, w_f3 == 3'd5 && w_f7[5]);
        o_ctrl.gpr_we = 1'b1;
        w_legal       = w_f3 == 3'd1 ? w_f7 == 7'd0 :
                        w_f3 == 3'd5 ? (w_f7 == 7'd0 || w_f7 == 7'b0100000) : 1'b1;
      end
      OPC_OP: begin
        o_ctrl.alu_op = alu_from_f3(w_f3, w_f7[5]);
        o_ctrl.gpr_we = 1'b1;
        w_legal       = w_f7 == 7'd0 || (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5));
`ifdef DECODE_STAGE_RV32M_EN
        if (w_f7 == 7'b0000001) begin
          o_ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(w_f3));
          w_legal       = 1'b1;
        end
`endif
      end
      OPC_FENCE: w_legal = w_f3 == 3'd0;
      OPC_SYSTEM: begin
        if (w_f3 == 3'd0) begin
          o_ctrl.mret = i_instr == INSTR_MRET;
          w_legal     = i_instr == INSTR_MRET;
        end else begin
          // CSRRS/CSRRC with rs1/uimm of zero are pure reads
          o_ctrl.csr_op = w_f3;
          o_ctrl.csr_we = !(w_f3[1] && i_instr[19:15] == 5'd0);
          o_ctrl.gpr_we = 1'b1;
          o_ctrl.wb_sel = WB_CSR;
          w_legal       = w_f3 != 3'd4;
        end
      end
      default: ;
    endcase
    if (!w_legal) begin
      o_ctrl               = '0;
      o_ctrl.illegal_instr = 1'b1;
    end
  end
endmodule

// File: rtl/decode_stage_pricol.sv
// decode_stage_pricol: queued decode stage (FIFO + registered control word); RV32M via DECODE_STAGE_RV32M_EN.
module decode_stage_pricol
  import decode_stage_pricol_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic clk_i,
  input logic rst_i,
  decode_stage_pricol_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  logic [31:0]     r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [FW-1:0]   r_fill;
  logic            r_valid;
  decode_ctrl_t    r_ctrl, w_head_ctrl;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic            w_ready, w_push, w_load;
  assign w_ready = r_fill < FW'(DEPTH);
  assign w_push  = bus.in_valid_i & w_ready & !bus.flush_i;
  assign w_load  = r_fill != '0 & (!r_valid | bus.out_ready_i) & !bus.flush_i;
  assign bus.in_ready_o  = w_ready;
  assign bus.out_valid_o = r_valid;
  assign bus.ctrl_o      = r_ctrl;
  assign bus.instr_o     = r_instr;
  assign bus.pc_o        = r_pc;
  assign bus.fill_o      = r_fill;
  decode_comb_pricol u_dec (
    .i_instr (r_mem_instr[r_rp]),
    .o_ctrl  (w_head_ctrl)
  );
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_instr[r_wp] <= bus.instr_i;
      r_mem_pc[r_wp]    <= bus.pc_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (bus.flush_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_load) begin
        r_rp    <= r_rp + AW'(1);
        r_ctrl  <= w_head_ctrl;
        r_instr <= r_mem_instr[r_rp];
        r_pc    <= r_mem_pc[r_rp];
      end
      r_valid <= w_load | (r_valid & !bus.out_ready_i);
      r_fill  <= r_fill + FW'(w_push) - FW'(w_load);
    end
  end
endmodule

// File: tb/tb_decode_stage_pricol.sv
// tb_decode_stage_pricol: directed checks of the queued decode stage.
module tb_decode_stage_pricol;
  import decode_stage_pricol_pkg::*;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  decode_stage_pricol_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();
  decode_stage_pricol #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  decode_ctrl_t c;
  assign c = decode_ctrl_t'(bus.ctrl_o);
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    bus.in_valid_i = v;
    bus.instr_i    = i;
    bus.pc_i       = p;
  endtask
  initial begin
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_fill", 64'(bus.fill_o), 64'd0);
    chk("rst_ctrl", 64'(bus.ctrl_o), 64'd0);
    chk("rst_instr", 64'(bus.instr_o), 64'd0);
    chk("rst_pc", 64'(bus.pc_o), 64'd0);
    #10 rst = 1'b0;
    step();
    chk("rel_ready", 64'(bus.in_ready_o), 64'd1);
    // ADDI x1,x0,5: visible after the second edge
    bus.out_ready_i = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_v_early", 64'(bus.out_valid_o), 64'd0);
    chk("addi_fill1", 64'(bus.fill_o), 64'd1);
    step();
    chk("addi_valid", 64'(bus.out_valid_o), 64'd1);
    chk("addi_asel", 64'(c.a_sel), 64'd0);
    chk("addi_bsel", 64'(c.b_sel), 64'd1);
    chk("addi_alu", 64'(c.alu_op), 64'd0);
    chk("addi_gpr_we", 64'(c.gpr_we), 64'd1);
    chk("addi_ill", 64'(c.illegal_instr), 64'd0);
    chk("addi_pc", 64'(bus.pc_o), 64'h100);
    chk("addi_fill0", 64'(bus.fill_o), 64'd0);
    step();
    chk("addi_drain", 64'(bus.out_valid_o), 64'd0);
    // SW then MRET back-to-back
    drive(1'b1, 32'h00112023, 32'h104);
    step();
    drive(1'b1, 32'h30200073, 32'h108);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("sw_instr", 64'(bus.instr_o), 64'h00112023);
    chk("sw_mem_req", 64'(c.mem_req), 64'd1);
    chk("sw_mem_we", 64'(c.mem_we), 64'd1);
    chk("sw_size", 64'(c.mem_size), 64'd2);
    chk("sw_bsel", 64'(c.b_sel), 64'd3);
    chk("sw_gpr_we", 64'(c.gpr_we), 64'd0);
    step();
    chk("mret_pc", 64'(bus.pc_o), 64'h108);
    chk("mret_mret", 64'(c.mret), 64'd1);
    chk("mret_gpr_we", 64'(c.gpr_we), 64'd0);
    chk("mret_ill", 64'(c.illegal_instr), 64'd0);
    step();
    // Backpressure: six offered, five held (4 in FIFO + 1 presented)
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h00000093 + (i << 20), 32'h200 + 4 * i);
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_fill", 64'(bus.fill_o), 64'd4);
    chk("bp_ready", 64'(bus.in_ready_o), 64'd0);
    chk("bp_valid", 64'(bus.out_valid_o), 64'd1);
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_out%0d_v", k), 64'(bus.out_valid_o), 64'd1);
      chk($sformatf("bp_out%0d_i", k), 64'(bus.instr_o), 64'h00000093 + (k << 20));
      chk($sformatf("bp_out%0d_pc", k), 64'(bus.pc_o), 64'h200 + 4 * k);
      step();
    end
    chk("bp_empty_v", 64'(bus.out_valid_o), 64'd0);
    chk("bp_empty_fill", 64'(bus.fill_o), 64'd0);
    // Illegal encodings
    drive(1'b1, 32'h00000000, 32'h400);
    step();
    drive(1'b1, 32'h00000073, 32'h404);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("ill0_ctrl", 64'(bus.ctrl_o), 64'h10);
    chk("ill0_flag", 64'(c.illegal_instr), 64'd1);
    step();
    chk("ecall_instr", 64'(bus.instr_o), 64'h73);
    chk("ecall_ctrl", 64'(bus.ctrl_o), 64'h10);
    step();
    // Flush with a full FIFO and a presented word
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h00100113 + (i << 20), 32'h500 + 4 * i);
      step();
    end
    chk("fl_pre_fill", 64'(bus.fill_o), 64'd4);
    chk("fl_pre_valid", 64'(bus.out_valid_o), 64'd1);
    bus.flush_i = 1'b1;
    drive(1'b1, 32'h00700093, 32'h600);
    step();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_fill", 64'(bus.fill_o), 64'd0);
    chk("fl_valid", 64'(bus.out_valid_o), 64'd0);
    chk("fl_ready", 64'(bus.in_ready_o), 64'd1);
    step();
    chk("fl_stay_v", 64'(bus.out_valid_o), 64'd0);
    bus.flush_i = 1'b1;
    drive(1'b1, 32'h00800093, 32'h604);
    step();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_drop_fill", 64'(bus.fill_o), 64'd0);
    bus.out_ready_i = 1'b1;
    drive(1'b1, 32'h00900093, 32'h300);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("post_fl_v", 64'(bus.out_valid_o), 64'd1);
    chk("post_fl_i", 64'(bus.instr_o), 64'h00900093);
    chk("post_fl_pc", 64'(bus.pc_o), 64'h300);
    // MUL x0,x1,x2
    drive(1'b1, 32'h02208033, 32'h700);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("mul_instr", 64'(bus.instr_o), 64'h02208033);
`ifdef DECODE_STAGE_RV32M_EN
    chk("mul_alu", 64'(c.alu_op), 64'd10);
    chk("mul_gpr_we", 64'(c.gpr_we), 64'd1);
    chk("mul_ill", 64'(c.illegal_instr), 64'd0);
`else
    chk("mul_ill", 64'(c.illegal_instr), 64'd1);
    chk("mul_gpr_we", 64'(c.gpr_we), 64'd0);
`endif
    step();
    // Asynchronous reset mid-stream
    bus.out_ready_i = 1'b0;
    drive(1'b1, 32'h00a00093, 32'h800);
    step();
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("mid_pre_v", 64'(bus.out_valid_o), 64'd1);
    chk("mid_pre_fill", 64'(bus.fill_o), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_v", 64'(bus.out_valid_o), 64'd0);
    chk("mid_rst_fill", 64'(bus.fill_o), 64'd0);
    chk("mid_rst_ctrl", 64'(bus.ctrl_o), 64'd0);
    #3 rst = 1'b0;
    step();
    chk("mid_rel_ready", 64'(bus.in_ready_o), 64'd1);
    chk("mid_rel_v", 64'(bus.out_valid_o), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
